// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port (fetch/data) memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    // Which port holds the pending read response
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    // Port most recently granted a memory slot
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: req[0] = fetch port, req[1] = data port.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == PORT_I) ? 2'b10 : 2'b01;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store data port onto one
// single-ported memory with 1-cycle read latency; grants are combinational.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,

    output logic [ADDR_W-1:0] mem_raddress,
    output logic [ADDR_W-1:0] mem_waddress,
    output logic [DATA_W-1:0] mem_datain,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_dataout
);

    owner_t     owner_q, owner_d;
    port_t      last_grant_q, last_grant_d;

    logic       d_misaligned;
    logic [1:0] arb_req;
    logic [1:0] arb_gnt;

    // A misaligned data request is rejected without using the memory slot,
    // so it never competes with the fetch port.
    always_comb begin
        d_misaligned = RESET && d_req && !word_aligned(d_addr[1:0]);
        arb_req[0]   = RESET && i_req;
        arb_req[1]   = RESET && d_req && !d_misaligned;
    end

    rr_arbiter2 u_rr (
        .req        (arb_req),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt)
    );

    always_comb begin
        i_gnt        = arb_gnt[0];
        d_gnt        = arb_gnt[1] || d_misaligned;
        d_err        = d_misaligned;

        mem_raddress = '0;
        mem_waddress = '0;
        mem_datain   = '0;
        mem_wr       = 1'b0;
        owner_d      = OWN_NONE;
        last_grant_d = last_grant_q;

        if (arb_gnt[0]) begin
            mem_raddress = i_addr;
            owner_d      = OWN_I;
            last_grant_d = PORT_I;
        end else if (arb_gnt[1]) begin
            last_grant_d = PORT_D;
            if (d_we) begin
                mem_wr       = 1'b1;
                mem_waddress = d_addr;
                mem_datain   = d_wdata;
            end else begin
                mem_raddress = d_addr;
                owner_d      = OWN_D;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            owner_q      <= OWN_NONE;
            last_grant_q <= PORT_I;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Response is gated by reset so a read in flight when reset hits is dropped.
    always_comb begin
        i_rvalid = RESET && (owner_q == OWN_I);
        d_rvalid = RESET && (owner_q == OWN_D);
        i_rdata  = i_rvalid ? mem_dataout : '0;
        d_rdata  = d_rvalid ? mem_dataout : '0;
    end

    rvalid_exclusive_a: assert property (@(posedge CLK) !(i_rvalid && d_rvalid));

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32: memory address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 32: memory data word width in bits.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  synchronous, active-low reset.
REQ-005 i_req  input  1  instruction-fetch read request.
REQ-006 i_addr  input  ADDR_W  instruction-fetch byte address.
REQ-007 i_gnt  output  1  fetch request accepted this cycle.
REQ-008 i_rvalid  output  1  i_rdata valid this cycle.
REQ-009 i_rdata  output  DATA_W  fetch read data.
REQ-010 d_req  input  1  data-port request.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  ADDR_W  data byte address.
REQ-013 d_wdata  input  DATA_W  store data.
REQ-014 d_gnt  output  1  data request accepted this cycle.
REQ-015 d_rvalid  output  1  d_rdata valid this cycle.
REQ-016 d_rdata  output  DATA_W  load data.
REQ-017 d_err  output  1  one-cycle pulse: misaligned data access rejected.
REQ-018 mem_raddress, mem_waddress  output  ADDR_W  read and write addresses to the shared 32-bit memory.
REQ-019 mem_datain  output  DATA_W, mem_wr  output  1, mem_dataout  input  DATA_W: memory write data, write enable, read data (1-cycle latency).

Function
REQ-020 The block SHALL issue at most one memory access (read or write) per cycle.
REQ-021 A grant SHALL be combinational in the request cycle; the access SHALL be presented to memory in that same cycle.
REQ-022 Only one requester: granted immediately. Both requesting: the port not granted most recently SHALL win (round-robin via last_grant register).
REQ-023 last_grant SHALL update only on a cycle with a grant; after reset last_grant = I, so first contention goes to D.
REQ-024 Granted read: mem_raddress = requester address; exactly one cycle later the owner's rvalid SHALL pulse with rdata = mem_dataout.
REQ-025 Read ownership SHALL be held in a one-entry owner register (NONE/I/D); rvalid SHALL be delivered even if the requester has dropped req.
REQ-026 Granted store: mem_wr = 1, mem_waddress = d_addr, mem_datain = d_wdata for that cycle only; d_gnt is the store's completion; no rvalid.
REQ-027 d_addr[1:0] != 00: d_gnt = 1, d_err = 1 that cycle, no memory access, last_grant unchanged, no rvalid.
REQ-028 i_addr is not alignment-checked; bits [1:0] SHALL pass through unchanged.
REQ-029 A requester not granted SHALL hold req/addr/data stable until granted; the block is not required to tolerate changes.
REQ-030 Idle cycles: mem_wr = 0, mem_raddress = 0, mem_waddress = 0, mem_datain = 0.
REQ-031 Read granted in the cycle after a store to the same address SHALL return the stored data (no bypass; memory ordering).
REQ-032 Back-to-back grants to either port SHALL be allowed every cycle; the two rvalid outputs SHALL never both be 1.

Reset
REQ-033 While RESET = 0 at a rising edge: owner = NONE, last_grant = I; all gnt, rvalid, d_err, mem_wr SHALL be 0, rdata outputs 0.
REQ-034 Reset asserted with a read outstanding SHALL drop the rvalid; no grant SHALL occur in a reset cycle.

Structure
REQ-035 Package mem_arb_pkg SHALL hold ADDR_W/DATA_W defaults and enum owner_t {OWN_NONE, OWN_I, OWN_D}.
REQ-036 The round-robin decision SHALL be a sub-module rr_arbiter2 (req[1:0], last_grant in, gnt[1:0] out, combinational).

Verification
REQ-037 Single fetch i_addr=0x10, mem holds 0xDEADBEEF: i_gnt same cycle, i_rvalid next cycle, i_rdata=0xDEADBEEF.
REQ-038 Both request continuously for 4 cycles after reset: grants D,I,D,I; rvalids follow one cycle later with matching owner.
REQ-039 Store d_addr=0x20, d_wdata=0x12345678, then load 0x20 next cycle: mem_wr pulse once, d_rdata=0x12345678.
REQ-040 d_addr=0x22 load: d_gnt=1, d_err=1, mem_wr=0, no d_rvalid; concurrent i_req granted that cycle.
REQ-041 Fetch granted, RESET=0 next cycle: i_rvalid stays 0; after release first contention goes to D.
REQ-042 Fetch granted, i_req dropped next cycle: i_rvalid still pulses with correct data.
